// File: rtl/spi_master_fsm_param.sv
// -----------------------------------------------------------------------------
// spi_master_fsm_param
//   Parametrised SPI master sequencer. Runs a burst of (n_tx_end_i + 1) frames
//   of DATA_W bits, reading TX words from a word-addressed buffer and writing
//   each received word back at the same frame index. It supports all four
//   CPOL/CPHA modes, N_CS one-hot active-low chip selects, an SCLK divider of
//   CLK_DIV clk_i cycles per half-period, and an optional CS hold between frames.
//
// Optional feature macro: SPI_MASTER_FSM_LSB_FIRST_EN
//   When defined, the input lsb_first_i is added. It is latched at start, and
//   when it is 1 both TX and RX shift LSB first. When undefined, shifting is
//   always MSB first.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             begin a burst (sampled in IDLE only)
//   n_tx_end_i          last frame index of the burst
//   cpol_i, cpha_i      SPI mode
//   cs_sel_i            slave index (values >= N_CS select nobody)
//   cs_hold_i           keep CS low between frames
//   all_0s_i, all_1s_i  send a constant instead of buffer data (all_0s wins)
//   tx_addr_o/tx_data_i combinational TX buffer read port
//   rx_addr_o/rx_data_o/rx_we_o  RX buffer write port (one-cycle strobe)
//   sclk_o, mosi_o, miso_i, cs_n_o  SPI pins
//   busy_o, done_o      burst in progress / one-cycle end-of-burst pulse
//   frame_cnt_o         frames completed in the current or last burst
//   dbg_state_o         current FSM state encoding (state_e)
//
// Handshake: start_i is a level sampled only while IDLE and busy_o is low. Any
// start_i seen during a burst has no effect. done_o pulses for exactly one
// cycle, and the next start_i can be taken in the cycle that follows it.
// -----------------------------------------------------------------------------
module spi_master_fsm_param #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 10,
  parameter int N_CS    = 1,
  parameter int CLK_DIV = 2,
  localparam int CS_W   = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_tx_end_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              cs_hold_i,
  input  logic              all_0s_i,
  input  logic              all_1s_i,
`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
  input  logic              lsb_first_i,
`endif
  output logic [CNT_W-1:0]  tx_addr_o,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [CNT_W-1:0]  rx_addr_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_we_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [N_CS-1:0]   cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic [2:0]        dbg_state_o
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    idx_q;        // frame index: drives both buffer addresses
  logic [CNT_W-1:0]    n_end_q;
  logic [CNT_W-1:0]    frame_cnt_q;
  logic                cpha_q;
  logic [CS_W-1:0]     cs_sel_q;
  logic                cs_hold_q;
  logic                all_0s_q;
  logic                all_1s_q;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;       // SCLK edges already issued in this frame
  logic [DATA_W-1:0]   tx_sr_q;
  logic [DATA_W-1:0]   rx_sr_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_we_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [N_CS-1:0]     cs_n_q;
  logic                busy_q;
  logic                done_q;
  logic                lsb_first;

`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
  logic                lsb_q;
  assign lsb_first = lsb_q;
`else
  assign lsb_first = 1'b0;
`endif

  // One-hot active-low decode. An out-of-range index selects no slave.
  function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [N_CS-1:0] v;
    v = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (sel == CS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  logic [DATA_W-1:0] load_word_d;
  logic [DATA_W-1:0] load_shift_d;
  logic              load_top_d;
  logic [DATA_W-1:0] tx_shift_d;
  logic              tx_top_d;
  logic [DATA_W-1:0] rx_shift_d;
  logic              div_wrap_d;
  logic              last_edge_d;
  logic              sample_edge_d;

  always_comb begin
    load_word_d = tx_data_i;
    if (all_0s_q)      load_word_d = '0;
    else if (all_1s_q) load_word_d = '1;

    load_top_d   = lsb_first ? load_word_d[0] : load_word_d[DATA_W-1];
    load_shift_d = lsb_first ? {1'b0, load_word_d[DATA_W-1:1]}
                             : {load_word_d[DATA_W-2:0], 1'b0};
    tx_top_d     = lsb_first ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
    tx_shift_d   = lsb_first ? {1'b0, tx_sr_q[DATA_W-1:1]}
                             : {tx_sr_q[DATA_W-2:0], 1'b0};
    rx_shift_d   = lsb_first ? {miso_i, rx_sr_q[DATA_W-1:1]}
                             : {rx_sr_q[DATA_W-2:0], miso_i};

    div_wrap_d    = (div_q == DIV_W'(CLK_DIV - 1));
    last_edge_d   = (edge_q == EDGE_W'(2 * DATA_W - 1));
    // The edge about to be issued is leading when an even number of edges has
    // already gone out. CPHA=0 samples on leading edges and CPHA=1 on trailing.
    sample_edge_d = (~edge_q[0]) ^ cpha_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      n_end_q     <= '0;
      frame_cnt_q <= '0;
      cpha_q      <= 1'b0;
      cs_sel_q    <= '0;
      cs_hold_q   <= 1'b0;
      all_0s_q    <= 1'b0;
      all_1s_q    <= 1'b0;
      div_q       <= '0;
      edge_q      <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_we_q     <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
      lsb_q       <= 1'b0;
`endif
    end else begin
      rx_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // sclk_q follows CPOL while idle. At start it therefore already holds
          // the latched idle level, and the SHIFT toggles begin from it.
          sclk_q <= cpol_i;
          cs_n_q <= '1;
          if (start_i) begin
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            n_end_q     <= n_tx_end_i;
            cpha_q      <= cpha_i;
            cs_sel_q    <= cs_sel_i;
            cs_hold_q   <= cs_hold_i;
            all_0s_q    <= all_0s_i;
            all_1s_q    <= all_1s_i;
            cs_n_q      <= cs_decode(cs_sel_i);
`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
            lsb_q       <= lsb_first_i;
`endif
          end
        end

        ST_LOAD: begin
          div_q   <= '0;
          edge_q  <= '0;
          rx_sr_q <= '0;
          if (cpha_q) begin
            tx_sr_q <= load_word_d;      // first bit goes out on the leading edge
          end else begin
            tx_sr_q <= load_shift_d;     // first bit is presented on SHIFT entry
            mosi_q  <= load_top_d;
          end
          state_q <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (div_wrap_d) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            if (sample_edge_d) begin
              rx_sr_q <= rx_shift_d;
            end else if (!last_edge_d) begin
              // For CPHA=0 the final trailing edge would move past the last bit,
              // so MOSI is held instead.
              mosi_q  <= tx_top_d;
              tx_sr_q <= tx_shift_d;
            end
            if (last_edge_d) begin
              state_q     <= ST_STORE;
              rx_we_q     <= 1'b1;
              rx_data_q   <= sample_edge_d ? rx_shift_d : rx_sr_q;
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_STORE: begin
          if (idx_q == n_end_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            cs_n_q  <= '1;
          end else begin
            state_q <= ST_NEXT;
            if (!cs_hold_q) cs_n_q <= '1;
          end
        end

        ST_NEXT: begin
          idx_q   <= idx_q + 1'b1;
          cs_n_q  <= cs_decode(cs_sel_q);
          state_q <= ST_LOAD;
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          cs_n_q  <= '1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_addr_o   = idx_q;
  assign rx_addr_o   = idx_q;
  assign rx_data_o   = rx_data_q;
  assign rx_we_o     = rx_we_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign cs_n_o      = cs_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_fsm_param
//   Directed bench for spi_master_fsm_param using default parameters
//   (DATA_W=8, CNT_W=10, N_CS=1, CLK_DIV=2). A negedge monitor acts as the SPI
//   slave, captures MOSI on the slave's sampling edges and logs RX writes. The
//   main initial block runs the directed steps and checks the expected values.
// -----------------------------------------------------------------------------
module tb_spi_master_fsm_param;

  localparam int DW    = 8;
  localparam int CW    = 10;
  localparam int LIMIT = 1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start_i = 1'b0;
  logic [CW-1:0] n_tx_end_i = '0;
  logic          cpol_i = 1'b0, cpha_i = 1'b0;
  logic [0:0]    cs_sel_i = 1'b0;
  logic          cs_hold_i = 1'b0, all_0s_i = 1'b0, all_1s_i = 1'b0;
  logic          lsb_first_i = 1'b0;
  logic [CW-1:0] tx_addr_o, rx_addr_o, frame_cnt_o;
  logic [DW-1:0] tx_data_i, rx_data_o;
  logic          rx_we_o, sclk_o, mosi_o, miso_i, busy_o, done_o;
  logic [0:0]    cs_n_o;
  logic [2:0]    dbg_state_o;

  logic [DW-1:0] tx_mem [4];
  logic          loop_en = 1'b1;
  logic          slave_miso = 1'b0;
  logic [DW-1:0] slave_word = 8'hC3;

  assign tx_data_i = tx_mem[tx_addr_o[1:0]];
  assign miso_i    = loop_en ? mosi_o : slave_miso;

  spi_master_fsm_param dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_tx_end_i(n_tx_end_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .cs_sel_i(cs_sel_i), .cs_hold_i(cs_hold_i),
    .all_0s_i(all_0s_i), .all_1s_i(all_1s_i),
`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
    .lsb_first_i(lsb_first_i),
`endif
    .tx_addr_o(tx_addr_o), .tx_data_i(tx_data_i), .rx_addr_o(rx_addr_o),
    .rx_data_o(rx_data_o), .rx_we_o(rx_we_o), .sclk_o(sclk_o), .mosi_o(mosi_o),
    .miso_i(miso_i), .cs_n_o(cs_n_o), .busy_o(busy_o), .done_o(done_o),
    .frame_cnt_o(frame_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- monitor / slave model ----------------
  logic          clr_req = 1'b0;
  logic          mon_cpha = 1'b0;
  logic          sclk_prev = 1'b0;
  logic [DW-1:0] slave_sr = '0;
  logic [DW-1:0] mosi_cap = '0;
  logic [CW-1:0] rx_addr_log [$];
  logic [DW-1:0] rx_data_log [$];
  int frame_edges = 0, first_edge = 0, mon_cyc = 0;
  int done_cnt = 0, cs_rises = 0, cs_low = 0, mosi_low = 0, mosi_high = 0;

  always @(negedge clk) begin
    if (clr_req) begin
      rx_addr_log.delete();
      rx_data_log.delete();
      frame_edges = 0; first_edge = 0; mon_cyc = 0; done_cnt = 0;
      cs_rises = 0; cs_low = 0; mosi_low = 0; mosi_high = 0;
    end else begin
      if (busy_o) mon_cyc++;
      if (dbg_state_o == ST_LOAD) begin
        frame_edges = 0;
        mosi_cap = '0;
        if (!mon_cpha) begin
          slave_miso = slave_word[DW-1];
          slave_sr   = slave_word << 1;
        end else begin
          slave_sr   = slave_word;
        end
      end
      if ((dbg_state_o == ST_SHIFT || dbg_state_o == ST_STORE) && sclk_o !== sclk_prev) begin
        frame_edges++;
        if (first_edge == 0) first_edge = mon_cyc;
        // odd edge count = leading edge; slave samples where the master shifts not
        if (((frame_edges % 2) == 1) ^ mon_cpha) begin
          mosi_cap = {mosi_cap[DW-2:0], mosi_o};
        end else begin
          slave_miso = slave_sr[DW-1];
          slave_sr   = slave_sr << 1;
        end
      end
      if (dbg_state_o == ST_SHIFT) begin
        if (mosi_o) mosi_high++; else mosi_low++;
      end
      if (dbg_state_o == ST_NEXT && cs_n_o[0]) cs_rises++;
      if (!cs_n_o[0]) cs_low++;
      if (rx_we_o) begin
        rx_addr_log.push_back(rx_addr_o);
        rx_data_log.push_back(rx_data_o);
      end
      if (done_o) done_cnt++;
    end
    sclk_prev = sclk_o;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [CW-1:0] n_end, input logic cpol, input logic cpha,
                        input logic hold, input logic a0, input logic a1);
    n_tx_end_i = n_end; cpol_i = cpol; cpha_i = cpha; cs_hold_i = hold;
    all_0s_i = a0; all_1s_i = a1; mon_cpha = cpha;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("idle_sclk_level", sclk_o, cpol);
    check("idle_cs_n", cs_n_o, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_at_load", busy_o, 1);
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done_o !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check("done_seen", done_o, 1);
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int found;

  initial begin
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;

    // reset values
    repeat (3) tick();
    check("rst_sclk", sclk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_cs_n", cs_n_o, 1);
    check("rst_rx_we", rx_we_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_tx_addr", tx_addr_o, 0);
    check("rst_rx_addr", rx_addr_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_frame_cnt", frame_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    // mode 0, single frame, 0xA5 loopback
    loop_en = 1'b1;
    launch(0, 0, 0, 0, 0, 0);
    wait_done(1, cyc);
    check("m0_done_cycle", cyc, 35);
    check("m0_first_edge_cycle", first_edge, 4);
    check("m0_mosi_bits", mosi_cap, 8'hA5);
    check("m0_rx_we_count", rx_data_log.size(), 1);
    check("m0_rx_data", rx_data_log[0], 8'hA5);
    check("m0_rx_addr", rx_addr_log[0], 0);
    check("m0_frame_cnt", frame_cnt_o, 1);
    tick();
    check("m0_busy_falls", busy_o, 0);

    // modes 1..3 with slave returning 0xC3
    loop_en = 1'b0;
    slave_word = 8'hC3;
    tx_mem[0] = 8'h3C;
    for (int m = 1; m < 4; m++) begin
      launch(0, m[1], m[0], 0, 0, 0);
      wait_done(1, cyc);
      check("mode_rx_data", rx_data_log[0], 8'hC3);
      check("mode_slave_saw_mosi", mosi_cap, 8'h3C);
      check("mode_edge_count", frame_edges, 16);
      tick();
      tick();
      check("mode_idle_sclk_after", sclk_o, m[1]);
    end

    // four frames, CS released between frames, then held
    loop_en = 1'b1;
    tx_mem[0] = 8'h11;
    for (int h = 0; h < 2; h++) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(tx_mem[i]);
      launch(3, 0, 0, h[0], 0, 0);
      wait_done(1, cyc);
      check("burst_latency", cyc, 140);
      check("burst_frame_cnt", frame_cnt_o, 4);
      check("burst_rx_we_count", rx_data_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
        if (i < rx_data_log.size()) begin
          check("burst_rx_addr", rx_addr_log[i], i);
          check("burst_rx_data", rx_data_log[i], exp_q.pop_front());
        end
      end
      check("burst_cs_rises", cs_rises, (h == 0) ? 3 : 0);
      tick();
    end

    // constant data: all ones over a zero buffer, then both flags set
    tx_mem[0] = 8'h00;
    launch(0, 0, 0, 0, 0, 1);
    wait_done(1, cyc);
    check("all1_mosi_bits", mosi_cap, 8'hFF);
    check("all1_mosi_low_cycles", mosi_low, 0);
    tick();
    tx_mem[0] = 8'hFF;
    launch(0, 0, 0, 0, 1, 1);
    wait_done(1, cyc);
    check("all0_wins_mosi_bits", mosi_cap, 8'h00);
    check("all0_wins_mosi_high_cycles", mosi_high, 0);
    tick();

    // cs_sel out of range: no CS asserted, transfer still runs
    tx_mem[0] = 8'h5A;
    cs_sel_i = 1'b1;
    launch(0, 0, 0, 0, 0, 0);
    wait_done(1, cyc);
    check("nocs_cs_low_cycles", cs_low, 0);
    check("nocs_rx_data", rx_data_log[0], 8'h5A);
    cs_sel_i = 1'b0;
    tick();

    // start while busy is ignored
    tx_mem[0] = 8'hA5;
    launch(0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    n_tx_end_i = 5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(8, cyc);
    check("busy_start_done_cycle", cyc, 35);
    check("busy_start_frame_cnt", frame_cnt_o, 1);
    repeat (50) tick();
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_idle", busy_o, 0);

    // reset in the middle of frame 2
    launch(3, 0, 0, 0, 0, 0);
    found = 0;
    for (int k = 0; k < LIMIT && found == 0; k++) begin
      if (dbg_state_o == ST_SHIFT && tx_addr_o == 2) found = 1;
      else tick();
    end
    check("rst_mid_reached_frame2", found, 1);
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_cs_n", cs_n_o, 1);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_state", dbg_state_o, ST_IDLE);
    check("rst_mid_rx_we_before", rx_data_log.size(), 2);
    repeat (100) tick();
    check("rst_mid_no_more_rx_we", rx_data_log.size(), 2);
    check("rst_mid_no_done", done_cnt, 0);
    tx_mem[0] = 8'h11;
    launch(1, 0, 0, 0, 0, 0);
    wait_done(1, cyc);
    check("rst_after_latency", cyc, 70);
    check("rst_after_frame_cnt", frame_cnt_o, 2);
    check("rst_after_first_addr", rx_addr_log[0], 0);
    check("rst_after_first_data", rx_data_log[0], 8'h11);
    tick();

`ifdef SPI_MASTER_FSM_LSB_FIRST_EN
    // LSB first: 0x01 goes out as 1,0,0,0,0,0,0,0
    tx_mem[0] = 8'h01;
    lsb_first_i = 1'b1;
    launch(0, 0, 0, 0, 0, 0);
    wait_done(1, cyc);
    check("lsb_mosi_bits", mosi_cap, 8'h80);
    check("lsb_rx_data", rx_data_log[0], 8'h01);
    lsb_first_i = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
